// File: rtl/signal_seg_scan.sv
// ---------------------------------------------------------------------------
// signal_seg_scan
// Time-multiplexed seven-segment scanner for the elevator status/floor
// display. One digit is driven per clk380hz cycle; each digit shows either a
// status glyph (direction / door codes) or a hex glyph. Per-digit blanking
// and blinking are applied live. New display data is staged in a pending
// buffer and only committed at a frame boundary, so a frame never mixes old
// and new digits.
//
// Ports:
//   clk380hz  - scan clock, one digit per cycle
//   rst       - synchronous active-high reset
//   dataBus   - digit i code/value in dataBus[4i+3:4i]
//   modeBus   - bit i: 0 = status glyph, 1 = hex glyph
//   blankMask - bit i: digit i always dark
//   blinkMask - bit i: digit i dark during the blink-off phase
//   load      - capture dataBus/modeBus into the pending buffer
//   ready     - 1 when no update is pending
//   pos       - one-hot digit enable (inverted when ACTIVE_LOW)
//   seg       - seg[6:0] = g..a, seg[7] = dp (inverted when ACTIVE_LOW)
// ---------------------------------------------------------------------------
module signal_seg_scan #(
    parameter int DIGITS     = 4,
    parameter int BLINK_DIV  = 190,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk380hz,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   dataBus,
    input  logic [DIGITS-1:0]     modeBus,
    input  logic [DIGITS-1:0]     blankMask,
    input  logic [DIGITS-1:0]     blinkMask,
    input  logic                  load,
    output logic                  ready,
    output logic [DIGITS-1:0]     pos,
    output logic [7:0]            seg
);

    // Status codes shared with the controller firmware.
    localparam logic [3:0] RS_UP    = 4'h1;
    localparam logic [3:0] RS_DOWN  = 4'h2;
    localparam logic [3:0] RS_STOP  = 4'h3;
    localparam logic [3:0] DS_OPEN  = 4'h4;
    localparam logic [3:0] DS_CLOSE = 4'h5;
    localparam logic [3:0] INVALID  = 4'hF;

    localparam int              IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]   LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [15:0]     BLINK_LAST = 16'(BLINK_DIV - 1);
    localparam logic [DIGITS-1:0] POS_INV  = {DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]      SEG_INV    = {8{ACTIVE_LOW}};

    function automatic logic [6:0] status_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            RS_UP:    g = 7'h63;
            RS_DOWN:  g = 7'h5C;
            RS_STOP:  g = 7'h40;
            DS_OPEN:  g = 7'h36;
            DS_CLOSE: g = 7'h7F;
            INVALID:  g = 7'h40;
            default:  g = 7'h40;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] val);
        logic [6:0] g;
        case (val)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [IW-1:0]       idx_r, idx_next_s;
    logic [15:0]         blink_cnt_r, blink_cnt_next_s;
    logic                blink_on_r, blink_on_next_s;
    logic [4*DIGITS-1:0] pend_data_r, pend_data_next_s;
    logic [DIGITS-1:0]   pend_mode_r, pend_mode_next_s;
    logic                pending_r, pending_next_s;
    logic [4*DIGITS-1:0] disp_data_r, disp_data_next_s;
    logic [DIGITS-1:0]   disp_mode_r, disp_mode_next_s;
    logic                ready_r;
    logic [DIGITS-1:0]   pos_r, pos_pre_s;
    logic [7:0]          seg_r, seg_pre_s;
    logic                wrap_s;
    logic [3:0]          nibble_s;

    // Scan index, blink timebase and frame-synchronous update next-state.
    always_comb begin
        wrap_s           = (idx_r == LAST_IDX);
        idx_next_s       = idx_r;
        blink_cnt_next_s = blink_cnt_r;
        blink_on_next_s  = blink_on_r;
        pend_data_next_s = pend_data_r;
        pend_mode_next_s = pend_mode_r;
        pending_next_s   = pending_r;
        disp_data_next_s = disp_data_r;
        disp_mode_next_s = disp_mode_r;

        if (wrap_s) begin
            idx_next_s = '0;
        end else begin
            idx_next_s = idx_r + 1'b1;
        end

        if (blink_cnt_r >= BLINK_LAST) begin
            blink_cnt_next_s = 16'd0;
            blink_on_next_s  = ~blink_on_r;
        end else begin
            blink_cnt_next_s = blink_cnt_r + 16'd1;
        end

        // At the frame boundary a same-edge load bypasses the pending buffer.
        if (wrap_s) begin
            if (load) begin
                disp_data_next_s = dataBus;
                disp_mode_next_s = modeBus;
            end else if (pending_r) begin
                disp_data_next_s = pend_data_r;
                disp_mode_next_s = pend_mode_r;
            end else begin
                disp_data_next_s = disp_data_r;
            end
            pending_next_s = 1'b0;
        end else begin
            if (load) begin
                pend_data_next_s = dataBus;
                pend_mode_next_s = modeBus;
                pending_next_s   = 1'b1;
            end else begin
                pending_next_s = pending_r;
            end
        end
    end

    // Glyph lookup, blank/blink gating and one-hot enable for the current digit.
    always_comb begin
        nibble_s        = disp_data_r[{idx_r, 2'b00} +: 4];
        pos_pre_s       = '0;
        pos_pre_s[idx_r] = 1'b1;
        seg_pre_s       = 8'h00;
        if (blankMask[idx_r]) begin
            seg_pre_s = 8'h00;
        end else if (!blink_on_r && blinkMask[idx_r]) begin
            seg_pre_s = 8'h00;
        end else if (disp_mode_r[idx_r]) begin
            seg_pre_s = {1'b0, hex_glyph(nibble_s)};
        end else begin
            seg_pre_s = {1'b0, status_glyph(nibble_s)};
        end
    end

    // State and output registers; polarity inversion is applied here, reset included.
    always_ff @(posedge clk380hz) begin
        if (rst) begin
            idx_r       <= '0;
            blink_cnt_r <= 16'd0;
            blink_on_r  <= 1'b1;
            pend_data_r <= '0;
            pend_mode_r <= '0;
            pending_r   <= 1'b0;
            disp_data_r <= {DIGITS{INVALID}};
            disp_mode_r <= '0;
            ready_r     <= 1'b1;
            pos_r       <= POS_INV;
            seg_r       <= SEG_INV;
        end else begin
            idx_r       <= idx_next_s;
            blink_cnt_r <= blink_cnt_next_s;
            blink_on_r  <= blink_on_next_s;
            pend_data_r <= pend_data_next_s;
            pend_mode_r <= pend_mode_next_s;
            pending_r   <= pending_next_s;
            disp_data_r <= disp_data_next_s;
            disp_mode_r <= disp_mode_next_s;
            ready_r     <= ~pending_next_s;
            pos_r       <= pos_pre_s ^ POS_INV;
            seg_r       <= seg_pre_s ^ SEG_INV;
        end
    end

    assign ready = ready_r;
    assign pos   = pos_r;
    assign seg   = seg_r;

endmodule
